// File: rtl/machine_pkg.sv
// ----------------------------------------------------------------------------
// machine_pkg
// Shared widths, constants and the packer state type for the Machine result
// packer: 12-bit samples are packed pairwise into 8-bit bytes.
// ----------------------------------------------------------------------------
package machine_pkg;

    localparam int SAMPLE_W = 12;
    localparam int BYTE_W   = 8;

    // Fill value for the low nibble of the padding byte of a lone sample.
    localparam logic [3:0] PAD_NIBBLE = 4'h0;

    // Packer sequence for one sample pair A,B:
    //   IDLE -> HI_A (A[11:4]) -> WAIT_B -> MID ({A[3:0],B[11:8]}) -> LO_B (B[7:0])
    // A flush with no B available goes WAIT_B -> PAD ({A[3:0],PAD_NIBBLE}).
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI_A   = 3'd1,
        WAIT_B = 3'd2,
        MID    = 3'd3,
        LO_B   = 3'd4,
        PAD    = 3'd5
    } packer_state_e;

endpackage : machine_pkg

// File: rtl/machine_result_packer_if.sv
// ----------------------------------------------------------------------------
// machine_result_packer_if
// Bundles the sample input stream, the flush request and the packed byte
// output stream of the result packer.
//   in_data/in_valid/in_ready    : 12-bit sample stream into the packer
//   flush                        : one-cycle drain/terminate request
//   out_data/out_valid/out_ready : 8-bit byte stream out of the packer
//   out_last                     : final byte of a flushed stream
// Modports:
//   master : the surrounding system (drives samples, consumes bytes)
//   slave  : the packer itself
// ----------------------------------------------------------------------------
interface machine_result_packer_if;

    logic [machine_pkg::SAMPLE_W-1:0] in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic                             flush;
    logic [machine_pkg::BYTE_W-1:0]   out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output flush,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  flush,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

endinterface : machine_result_packer_if

// File: rtl/machine_sample_fifo.sv
// ----------------------------------------------------------------------------
// machine_sample_fifo
// Small synchronous FIFO holding result samples ahead of the packer.
// Ports:
//   clk, srst      : clock and synchronous active-high reset
//   push_i, wdata_i: write request and data (ignored while full)
//   pop_i          : read request (ignored while empty)
//   rdata_o        : head entry, valid combinationally while !empty_o
//   full_o, empty_o: occupancy flags
// Pointers carry one extra wrap bit so that full and empty are distinguished
// without a separate counter.
// ----------------------------------------------------------------------------
module machine_sample_fifo
    import machine_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_d;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_d;
            end
        end
    end

endmodule : machine_sample_fifo

// File: rtl/machine_result_packer.sv
// ----------------------------------------------------------------------------
// machine_result_packer
// Buffers 12-bit Machine results and packs sample pairs into three bytes,
// MSB first: A[11:4], {A[3:0],B[11:8]}, B[7:0]. A flush drains a lone odd
// sample as {A[3:0],0} and tags the final byte of the stream with out_last.
// Ports:
//   system1000     : clock
//   system1000_rst : synchronous active-high reset
//   bus (slave)    : sample input stream, flush, packed byte output stream
// All byte outputs are registered and hold while out_valid & !out_ready.
// ----------------------------------------------------------------------------
module machine_result_packer
    import machine_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    machine_result_packer_if.slave  bus
);

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rdata;

    packer_state_e       state_q;
    logic [SAMPLE_W-1:0] reg_a_q;
    logic [SAMPLE_W-1:0] reg_b_q;
    logic                flush_pending_q;
    logic [BYTE_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;

    logic                byte_accept;
    logic                flush_seen;
    logic                empty_after;

    machine_sample_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (system1000),
        .srst    (system1000_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // No write-through when full, even if the FSM pops in the same cycle.
    assign bus.in_ready = ~fifo_full;
    assign fifo_push    = bus.in_valid & ~fifo_full;
    assign fifo_pop     = ((state_q == IDLE) || (state_q == WAIT_B)) & ~fifo_empty;

    assign byte_accept  = out_valid_q & bus.out_ready;

    // out_last for B[7:0] is decided when LO_B is entered and then held, so
    // it must already account for a flush and a push landing on that edge:
    // a sample pushed alongside the flush still belongs to this stream.
    assign flush_seen   = flush_pending_q | bus.flush;
    assign empty_after  = fifo_empty & ~fifo_push;

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q         <= IDLE;
            reg_a_q         <= '0;
            reg_b_q         <= '0;
            flush_pending_q <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
        end else begin
            // Sticky flush request; the state arms below consume it.
            flush_pending_q <= flush_pending_q | bus.flush;

            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        reg_a_q     <= fifo_rdata;
                        out_data_q  <= fifo_rdata[SAMPLE_W-1:4];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= HI_A;
                    end else if (flush_pending_q) begin
                        // Nothing buffered: the flush ends an empty stream.
                        flush_pending_q <= 1'b0;
                    end
                end

                HI_A: begin
                    if (byte_accept) begin
                        out_valid_q <= 1'b0;
                        state_q     <= WAIT_B;
                    end
                end

                WAIT_B: begin
                    if (!fifo_empty) begin
                        reg_b_q     <= fifo_rdata;
                        out_data_q  <= {reg_a_q[3:0], fifo_rdata[SAMPLE_W-1:8]};
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= MID;
                    end else if (flush_pending_q) begin
                        out_data_q  <= {reg_a_q[3:0], PAD_NIBBLE};
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        state_q     <= PAD;
                    end
                end

                MID: begin
                    if (byte_accept) begin
                        out_data_q <= reg_b_q[7:0];
                        out_last_q <= flush_seen & empty_after;
                        state_q    <= LO_B;
                    end
                end

                LO_B: begin
                    if (byte_accept) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            flush_pending_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                end

                PAD: begin
                    if (byte_accept) begin
                        out_valid_q     <= 1'b0;
                        out_last_q      <= 1'b0;
                        flush_pending_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule : machine_result_packer

// File: tb/tb_machine_result_packer.sv
// ----------------------------------------------------------------------------
// tb_machine_result_packer
// Self-checking bench for machine_result_packer. Expected byte streams come
// from a bit-concatenation model of the packing rules; received bytes are
// collected by a monitor at the falling edge.
// ----------------------------------------------------------------------------
module tb_machine_result_packer;
    import machine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 1;    // 0: out_ready low, 1: high, 2: random
    logic [8:0] got_q[$];    // {last, data} of every accepted byte
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    machine_result_packer_if bus ();

    machine_result_packer #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    // Sink ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Byte monitor: a transfer is decided by the values held before the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_q.push_back({bus.out_last, bus.out_data});
                $display("byte %0d data=%02h last=%0b t=%0t",
                         got_q.size() - 1, bus.out_data, bus.out_last, $time);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference: pairs become a 24-bit word {A,B} cut into three bytes; a
    // lone trailing sample becomes {A,4'h0}. A flushed stream marks its final
    // byte as last.
    function automatic void model_stream(input logic [11:0] s[$], input bit flushed);
        logic [23:0] pair;
        logic [15:0] lone;
        exp_q.delete();
        for (int i = 0; i < s.size(); i += 2) begin
            if (i + 1 < s.size()) begin
                pair = {s[i], s[i+1]};
                exp_q.push_back({1'b0, pair[23:16]});
                exp_q.push_back({1'b0, pair[15:8]});
                exp_q.push_back({(flushed && (i + 2 == s.size())), pair[7:0]});
            end else begin
                lone = {s[i], 4'h0};
                exp_q.push_back({1'b0, lone[15:8]});
                exp_q.push_back({flushed, lone[7:0]});
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_sample(input logic [11:0] d, input logic fl, output bit ok);
        int w = 0;
        while (!bus.in_ready && w < 200) begin
            tick(1);
            w++;
        end
        ok = bus.in_ready;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.flush    = fl;
        tick(1);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        int w = 0;
        while (got_q.size() < n && w < 1000) begin
            tick(1);
            w++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        ready_mode   = 1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data got=%02h exp=00", bus.out_data);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_last got=%b exp=0", bus.out_last);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_pair();
        logic [11:0] smp[$];
        int base;
        bit ok;
        base = got_q.size();
        smp = '{12'hABC, 12'h123};
        push_sample(smp[0], 1'b0, ok);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_latency_early out_valid got=%b exp=0", bus.out_valid);
        end
        push_sample(smp[1], 1'b0, ok);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAB) begin
            failures++;
            $display("FAIL pair_latency out_valid=%b data=%02h exp valid=1 data=AB",
                     bus.out_valid, bus.out_data);
        end
        model_stream(smp, 1'b0);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pair_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL pair_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(10);
        checks++;
        if (got_q.size() != base + exp_q.size()) begin
            failures++;
            $display("FAIL pair_extra got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end
    endtask

    task automatic test_odd_flush();
        logic [11:0] smp[$];
        int base;
        bit ok;
        base = got_q.size();
        smp = '{12'h5A7};
        push_sample(smp[0], 1'b0, ok);
        tick(3);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        model_stream(smp, 1'b1);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL odd_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL odd_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(10);
        checks++;
        if (got_q.size() != base + exp_q.size() || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL odd_extra got=%0d bytes out_valid=%b exp=%0d bytes out_valid=0",
                     got_q.size() - base, bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_even_flush();
        logic [11:0] smp[$];
        int base;
        bit ok;
        base = got_q.size();
        smp = '{12'hFFF, 12'h001};
        push_sample(smp[0], 1'b0, ok);
        push_sample(smp[1], 1'b1, ok);
        model_stream(smp, 1'b1);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL even_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL even_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(10);
        checks++;
        if (got_q.size() != base + exp_q.size()) begin
            failures++;
            $display("FAIL even_extra got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] smp[$];
        int base;
        int idx;
        int unstable;
        int w;
        bit acc;
        bit ok;
        ready_mode = 0;
        tick(2);
        base = got_q.size();
        idx = 0;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'h100 + 12'(idx);
            acc = bus.in_ready;
            tick(1);
            if (acc) idx++;
            if (bus.out_valid === 1'b1 && bus.out_data !== 8'h10) unstable++;
        end
        checks++;
        if (idx != 5) begin
            failures++;
            $display("FAIL full_accepted got=%0d exp=5", idx);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_in_ready got=%b exp=0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || unstable != 0) begin
            failures++;
            $display("FAIL full_hold out_valid=%b data=%02h unstable=%0d exp valid=1 data=10 unstable=0",
                     bus.out_valid, bus.out_data, unstable);
        end
        checks++;
        if (got_q.size() != base) begin
            failures++;
            $display("FAIL full_no_transfer got=%0d bytes exp=0", got_q.size() - base);
        end
        ready_mode = 1;
        w = 0;
        while (idx < 6 && w < 50) begin
            bus.in_data = 12'h100 + 12'(idx);
            acc = bus.in_ready;
            tick(1);
            if (acc) idx++;
            w++;
        end
        bus.in_valid = 1'b0;
        smp = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105};
        model_stream(smp, 1'b0);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL full_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(5);
    endtask

    task automatic test_reset_mid_group();
        logic [11:0] smp[$];
        int base;
        bit ok;
        ready_mode = 1;
        base = got_q.size();
        push_sample(12'h9C4, 1'b0, ok);
        tick(3);
        checks++;
        if (got_q.size() != base + 1 || got_q[base] !== 9'h09C || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_first got=%0d bytes out_valid=%b exp=1 byte 09C out_valid=0",
                     got_q.size() - base, bus.out_valid);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state out_valid=%b in_ready=%b exp out_valid=0 in_ready=1",
                     bus.out_valid, bus.in_ready);
        end
        base = got_q.size();
        smp = '{12'h321, 12'h654};
        push_sample(smp[0], 1'b0, ok);
        push_sample(smp[1], 1'b0, ok);
        model_stream(smp, 1'b0);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrst_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL midrst_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(10);
        checks++;
        if (got_q.size() != base + exp_q.size()) begin
            failures++;
            $display("FAIL midrst_extra got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end
    endtask

    task automatic test_empty_flush();
        logic [11:0] smp[$];
        int base;
        int seen;
        bit ok;
        ready_mode = 1;
        base = got_q.size();
        seen = 0;
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid !== 1'b0) seen++;
            tick(1);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL eflush_quiet got=%0d valid cycles exp=0", seen);
        end
        smp = '{12'h000, 12'hFFF};
        push_sample(smp[0], 1'b0, ok);
        push_sample(smp[1], 1'b0, ok);
        model_stream(smp, 1'b0);
        wait_bytes(base + exp_q.size(), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL eflush_timeout got=%0d bytes exp=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL eflush_byte%0d got=%03h exp=%03h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        tick(5);
    endtask

    task automatic test_random();
        logic [11:0] smp[$];
        int base;
        int n;
        bit ok;
        ready_mode = 2;
        for (int b = 0; b < 8; b++) begin
            base = got_q.size();
            n = $urandom_range(1, 7);
            smp.delete();
            for (int i = 0; i < n; i++) begin
                smp.push_back(12'($urandom));
            end
            for (int i = 0; i < n; i++) begin
                tick($urandom_range(0, 2));
                push_sample(smp[i], (i == n - 1), ok);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL rand_push burst%0d sample%0d in_ready never rose", b, i);
                end
            end
            model_stream(smp, 1'b1);
            wait_bytes(base + exp_q.size(), ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand_timeout burst%0d got=%0d bytes exp=%0d",
                         b, got_q.size() - base, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[base+i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand_burst%0d_byte%0d got=%03h exp=%03h",
                                 b, i, got_q[base+i], exp_q[i]);
                    end
                end
            end
            tick(6);
            checks++;
            if (got_q.size() != base + exp_q.size()) begin
                failures++;
                $display("FAIL rand_extra burst%0d got=%0d bytes exp=%0d",
                         b, got_q.size() - base, exp_q.size());
            end
        end
        ready_mode = 1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_pair();
        test_odd_flush();
        test_even_flush();
        test_backpressure();
        test_reset_mid_group();
        test_empty_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_machine_result_packer
